// File: rtl/storage_averager.sv
// Averages each point across the 10 stored frames and streams one
// 12-bit average per point over a valid/ready handshake.
module storage_averager #(
    parameter int unsigned POINTS = 10,
    parameter int unsigned FRAMES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [12*POINTS*FRAMES-1:0]  storage,
    input  logic                         save_stb,
    input  logic                         start,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [11:0]                  out_data,
    output logic [10:0]                  out_point,
    output logic                         busy,
    output logic                         done,
    output logic [3:0]                   frames
);

    typedef enum logic [2:0] {StIdle, StAccum, StDiv, StOut, StDone} state_t;

    state_t                        state_q, state_d;
    logic [3:0]                    frames_q, frames_d;
    logic [12*POINTS*FRAMES-1:0]   snap_q, snap_d;
    logic [15:0]                   acc_q, acc_d;
    logic [10:0]                   p_q, p_d;
    logic [3:0]                    k_q, k_d;
    logic                          out_valid_q, out_valid_d;
    logic [11:0]                   out_data_q, out_data_d;
    logic [10:0]                   out_point_q, out_point_d;

    logic [31:0] sel_idx;
    logic [11:0] sample;
    logic [11:0] quot;
    logic        start_ok;

    assign sel_idx  = 32'(k_q) * POINTS + 32'(p_q);
    assign sample   = 12'(snap_q >> (12 * sel_idx));
    // Reciprocal multiply: exact floor(acc/10) for every acc up to 10*4095.
    assign quot     = 12'((32'(acc_q) * 32'd52429) >> 19);
    assign start_ok = (state_q == StIdle) && start && (frames_q == 4'(FRAMES));

    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        snap_d      = snap_q;
        acc_d       = acc_q;
        p_d         = p_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_point_d = out_point_q;

        if (save_stb && (frames_q != 4'(FRAMES))) begin
            frames_d = frames_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    snap_d  = storage;
                    p_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                acc_d = acc_q + 16'(sample);
                if (k_q == 4'(FRAMES - 1)) begin
                    state_d = StDiv;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StDiv: begin
                out_data_d  = quot;
                out_point_d = p_q;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (p_q == 11'(POINTS - 1)) begin
                        state_d = StDone;
                    end else begin
                        p_d     = p_q + 11'd1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = StAccum;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            frames_q    <= '0;
            snap_q      <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_point_q <= '0;
        end else begin
            state_q     <= state_d;
            frames_q    <= frames_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_point_q <= out_point_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_point = out_point_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign frames    = frames_q;

endmodule

// File: tb/tb_storage_averager.sv
// Scoreboard bench for storage_averager: stimulus pushes expected averages,
// a negedge monitor pops and compares on every handshake.
module tb_storage_averager;

    localparam int POINTS = 10;
    localparam int FRAMES = 10;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [12*POINTS*FRAMES-1:0] storage;
    logic                        save_stb = 1'b0;
    logic                        start = 1'b0;
    logic                        out_ready = 1'b1;
    logic                        out_valid;
    logic [11:0]                 out_data;
    logic [10:0]                 out_point;
    logic                        busy;
    logic                        done;
    logic [3:0]                  frames;

    logic [11:0] mem [FRAMES][POINTS];

    typedef struct packed {
        logic [10:0] point;
        logic [11:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    storage_averager #(.POINTS(POINTS), .FRAMES(FRAMES)) dut (
        .clk       (clk),
        .rst       (rst),
        .storage   (storage),
        .save_stb  (save_stb),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_point (out_point),
        .busy      (busy),
        .done      (done),
        .frames    (frames)
    );

    always #5 clk = ~clk;

    always_comb begin
        storage = '0;
        for (int k = 0; k < FRAMES; k++) begin
            for (int p = 0; p < POINTS; p++) begin
                storage[12*(POINTS*k + p) +: 12] = mem[k][p];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compare on handshake, and require held outputs during back-pressure.
    logic        held = 1'b0;
    logic [11:0] held_data;
    logic [10:0] held_point;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_data));
                check("stall_point", 32'(out_point), 32'(held_point));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_point), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_point", 32'(out_point), 32'(e.point));
                    check("out_data", 32'(out_data), 32'(e.data));
                end
            end
            held       = out_valid && !out_ready;
            held_data  = out_data;
            held_point = out_point;
        end
    end

    task automatic pulse_save(input int n);
        repeat (n) begin
            @(posedge clk); #1 save_stb = 1'b1;
            @(posedge clk); #1 save_stb = 1'b0;
        end
    endtask

    task automatic push_exp(input int p, input int d);
        exp_t e;
        e.point = 11'(p);
        e.data  = 12'(d);
        exp_q.push_back(e);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < FRAMES; k++)
            for (int p = 0; p < POINTS; p++)
                mem[k][p] = 12'(10*p + k);
    endtask

    // One pass; stall holds out_ready low 5 cycles on point 3 and pokes
    // save_stb, storage and start while the pass is in flight.
    task automatic run_pass(input bit stall, input string tag);
        int cyc = 0;
        int first = -1;
        int done_at = -1;
        int stall_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (done_at < 0 && cyc < 1000) begin
            if (out_valid && first < 0) first = cyc;
            if (done) done_at = cyc;
            save_stb = 1'b0;
            start    = 1'b0;
            if (stall && out_valid && out_point == 11'd3 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                if (stall_cnt == 2) begin
                    save_stb = 1'b1;
                    for (int k = 0; k < FRAMES; k++)
                        for (int p = 0; p < POINTS; p++)
                            mem[k][p] = 12'd4095;
                end
                if (stall_cnt == 3) start = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
            if (done_at < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        save_stb  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_first_valid_latency"}, 32'(first), 32'd11);
        // DONE is entered on edge 12*POINTS after the start edge, plus stall cycles.
        check({tag, "_done_latency"}, 32'(done_at), 32'(12*POINTS + (stall ? 5 : 0)));
        check({tag, "_frames"}, 32'(frames), 32'd10);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < FRAMES; k++)
            for (int p = 0; p < POINTS; p++)
                mem[k][p] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_point", 32'(out_point), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
        rst = 1'b0;

        // Start with no frames stored must be ignored.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("early_start_busy", 32'(busy), 32'd0);
        check("early_start_valid", 32'(out_valid), 32'd0);

        pulse_save(10);
        #1 check("frames_full", 32'(frames), 32'd10);
        pulse_save(1);
        #1 check("frames_saturate", 32'(frames), 32'd10);

        // All 4095.
        for (int k = 0; k < FRAMES; k++)
            for (int p = 0; p < POINTS; p++)
                mem[k][p] = 12'd4095;
        for (int p = 0; p < POINTS; p++) push_exp(p, 4095);
        run_pass(1'b0, "max");

        // Point p, frame k = 10p+k: sum 100p+45, average 10p+4.
        load_ramp();
        for (int p = 0; p < POINTS; p++) push_exp(p, 10*p + 4);
        run_pass(1'b0, "ramp");

        // Floor-division boundaries.
        for (int k = 0; k < FRAMES; k++) begin
            mem[k][0] = (k == 0) ? 12'd1 : 12'd0;   // sum 1     -> 0
            mem[k][1] = 12'd9;                       // sum 90    -> 9
            mem[k][2] = (k == 9) ? 12'd10 : 12'd0;  // sum 10    -> 1
            mem[k][3] = 12'd4094;                    // sum 40940 -> 4094
            mem[k][4] = (k == 0) ? 12'd19 : 12'd0;  // sum 19    -> 1
            mem[k][5] = (k == 9) ? 12'd4094 : 12'd4095; // 40949 -> 4094
            mem[k][6] = 12'd1;                       // sum 10    -> 1
            mem[k][7] = (k == 0) ? 12'd9 : 12'd0;   // sum 9     -> 0
            mem[k][8] = 12'd0;                       // sum 0     -> 0
            mem[k][9] = 12'd4095;                    // sum 40950 -> 4095
        end
        push_exp(0, 0);    push_exp(1, 9);    push_exp(2, 1);    push_exp(3, 4094);
        push_exp(4, 1);    push_exp(5, 4094); push_exp(6, 1);    push_exp(7, 0);
        push_exp(8, 0);    push_exp(9, 4095);
        run_pass(1'b0, "bound");

        // Back-pressure plus mid-pass storage change: snapshot must still give the ramp.
        load_ramp();
        for (int p = 0; p < POINTS; p++) push_exp(p, 10*p + 4);
        run_pass(1'b1, "stall");

        // Reset during ACCUM of point 4 (edges 48..57 after the start edge).
        load_ramp();
        for (int p = 0; p < POINTS; p++) push_exp(p, 10*p + 4);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (52) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_valid", 32'(out_valid), 32'd0);
        check("pre_reset_outputs_seen", 32'(exp_q.size()), 32'd6);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", 32'(out_data), 32'd0);
        check("abort_point", 32'(out_point), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_frames", 32'(frames), 32'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
        end

        pulse_save(10);
        #1 check("refill_frames", 32'(frames), 32'd10);
        for (int p = 0; p < POINTS; p++) push_exp(p, 10*p + 4);
        run_pass(1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
